// File: rtl/task_admit_arbiter.sv
// task_admit_arbiter: round-robin admit/reject of per-tree push/pop requests into LEVEL TaskFIFO lanes
// Ports: i_clk/i_rst clock and synchronous active-high reset; i_req_valid/i_req_push/i_req_data per-tree
// requests with one-hot o_req_ready grant; i_flush_valid/i_flush_tree clear one tree's occupancy;
// i_TaskFIFO_full lane full flags; o_push_TaskFIFO/o_TaskFIFO_data registered lane write
// {push, treeId, data}; o_reject/o_reject_tree registered reject pulse; o_tree_cnt per-tree occupancy.
module task_admit_arbiter #(
  parameter int PTW = 16,
  parameter int MTW = 16,
  parameter int LEVEL = 4,
  parameter int TREE_NUM = 4,
  parameter int TREE_CAP = 64,
  parameter int LEVEL_BITS = $clog2(LEVEL),
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int CNT_BITS = $clog2(TREE_CAP + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [TREE_NUM-1:0]                  i_req_valid,
  input  logic [TREE_NUM-1:0]                  i_req_push,
  input  logic [(PTW+MTW)*TREE_NUM-1:0]        i_req_data,
  output logic [TREE_NUM-1:0]                  o_req_ready,
  input  logic                                 i_flush_valid,
  input  logic [TREE_NUM_BITS-1:0]             i_flush_tree,
  input  logic [LEVEL-1:0]                     i_TaskFIFO_full,
  output logic [LEVEL-1:0]                     o_push_TaskFIFO,
  output logic [PTW+MTW+TREE_NUM_BITS:0]       o_TaskFIFO_data,
  output logic                                 o_reject,
  output logic [TREE_NUM_BITS-1:0]             o_reject_tree,
  output logic [CNT_BITS*TREE_NUM-1:0]         o_tree_cnt
);
  localparam int DW = PTW + MTW;
  localparam logic [LEVEL_BITS:0] LV = (LEVEL_BITS+1)'(LEVEL);
  localparam logic [TREE_NUM_BITS:0] TV = (TREE_NUM_BITS+1)'(TREE_NUM);
  localparam logic [CNT_BITS-1:0] CAP = CNT_BITS'(TREE_CAP);
  logic [CNT_BITS-1:0] cnt [TREE_NUM];
  logic [LEVEL_BITS-1:0] lane_ptr, lane_sel, lane_idx;
  logic [TREE_NUM_BITS-1:0] tree_ptr, gnt_sel, tree_idx;
  logic lane_found, gnt_found, gnt_adm, gnt_push;
  logic [TREE_NUM-1:0] adm, elig;

  // explicit compare-and-subtract wrap so non-power-of-two counts work
  function automatic logic [LEVEL_BITS-1:0] lane_wrap(input logic [LEVEL_BITS:0] s);
    return s >= LV ? LEVEL_BITS'(s - LV) : LEVEL_BITS'(s);
  endfunction

  function automatic logic [TREE_NUM_BITS-1:0] tree_wrap(input logic [TREE_NUM_BITS:0] s);
    return s >= TV ? TREE_NUM_BITS'(s - TV) : TREE_NUM_BITS'(s);
  endfunction

  // walk the ring backwards so the last hit is the first lane from lane_ptr;
  // the lane written last cycle is skipped because its full flag lags one cycle
  always_comb begin
    lane_found = 1'b0;
    lane_sel = '0;
    lane_idx = '0;
    for (int k = LEVEL - 1; k >= 0; k--) begin
      lane_idx = lane_wrap({1'b0, lane_ptr} + (LEVEL_BITS+1)'(k));
      if (!i_TaskFIFO_full[lane_idx] && !o_push_TaskFIFO[lane_idx]) begin
        lane_found = 1'b1;
        lane_sel = lane_idx;
      end
    end
  end

  // rejects need no lane, so they stay eligible when all lanes are busy
  always_comb begin
    adm = '0;
    elig = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      adm[t] = i_req_push[t] ? cnt[t] < CAP : cnt[t] != '0;
      elig[t] = i_req_valid[t] && !(i_flush_valid && i_flush_tree == TREE_NUM_BITS'(t))
                && (!adm[t] || lane_found);
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_sel = '0;
    tree_idx = '0;
    for (int k = TREE_NUM - 1; k >= 0; k--) begin
      tree_idx = tree_wrap({1'b0, tree_ptr} + (TREE_NUM_BITS+1)'(k));
      if (elig[tree_idx]) begin
        gnt_found = 1'b1;
        gnt_sel = tree_idx;
      end
    end
  end

  assign gnt_adm = adm[gnt_sel];
  assign gnt_push = i_req_push[gnt_sel];
  assign o_req_ready = (gnt_found && !i_rst) ? TREE_NUM'(1) << gnt_sel : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < TREE_NUM; t++) cnt[t] <= '0;
      tree_ptr <= '0;
      lane_ptr <= '0;
      o_push_TaskFIFO <= '0;
      o_TaskFIFO_data <= '0;
      o_reject <= 1'b0;
      o_reject_tree <= '0;
    end else begin
      o_push_TaskFIFO <= '0;
      o_reject <= 1'b0;
      if (gnt_found) begin
        tree_ptr <= tree_wrap({1'b0, gnt_sel} + (TREE_NUM_BITS+1)'(1));
        if (gnt_adm) begin
          o_push_TaskFIFO <= LEVEL'(1) << lane_sel;
          o_TaskFIFO_data <= {gnt_push, gnt_sel, gnt_push ? i_req_data[gnt_sel*DW +: DW] : DW'(0)};
          cnt[gnt_sel] <= gnt_push ? cnt[gnt_sel] + 1'b1 : cnt[gnt_sel] - 1'b1;
          lane_ptr <= lane_wrap({1'b0, lane_sel} + (LEVEL_BITS+1)'(1));
        end else begin
          o_reject <= 1'b1;
          o_reject_tree <= gnt_sel;
        end
      end
      // a flushed tree is never granted in the same cycle, so this cannot race the update above
      if (i_flush_valid) cnt[i_flush_tree] <= '0;
    end
  end

  for (genvar g = 0; g < TREE_NUM; g++) begin : g_cnt
    assign o_tree_cnt[g*CNT_BITS +: CNT_BITS] = cnt[g];
  end
endmodule
